// File: rtl/weight_loader_pkg.sv
// ----------------------------------------------------------------------------
// weight_loader_pkg
// Shared constants, FSM state encoding and a byte-lane merge helper for the
// layer-1 weight loader and its pack RAM.
//   DW      : weight width
//   N_ROW/N_COL/N_W : 11 x 7 = 77 weights per set
//   WPW     : weights per packed 72-bit word
//   N_WORD  : packed words per set (= weight-buffer DFF chain depth)
// Optional feature macro used by the loader: WEIGHT_PREFETCH_EN
// ----------------------------------------------------------------------------
package weight_loader_pkg;

  localparam int DW     = 8;
  localparam int N_ROW  = 11;
  localparam int N_COL  = 7;
  localparam int N_W    = N_ROW * N_COL;
  localparam int WPW    = 9;
  localparam int N_WORD = 9;
  localparam int WORD_W = WPW * DW;

  // Lowest bit of the unused lanes in the last word (slots 5..8 of word 8).
  localparam int PAD_LO = (N_W - (N_WORD - 1) * WPW) * DW;

  localparam logic [6:0] K_LAST    = 7'(N_W - 1);
  localparam logic [3:0] SLOT_LAST = 4'(WPW - 1);
  localparam logic [3:0] WORD_LAST = 4'(N_WORD - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LOADED = 2'd2,
    ST_SWAP   = 2'd3
  } state_e;

  // Replace byte lane 'slot' of 'word' with 'b'.
  function automatic logic [WORD_W-1:0] merge_lane(input logic [WORD_W-1:0] word,
                                                   input logic [3:0]        slot,
                                                   input logic [DW-1:0]     b);
    logic [WORD_W-1:0] r;
    r = word;
    r[{slot, 3'b000} +: DW] = b;
    return r;
  endfunction

endpackage

// File: rtl/weight_loader_pack_ram.sv
// ----------------------------------------------------------------------------
// weight_loader_pack_ram
// 9 x 72-bit register file that assembles weight bytes into packed words.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears contents)
//   we_i           : write one byte lane
//   waddr_i        : word address 0..8
//   wslot_i        : byte lane 0..8 within the word
//   wdata_i        : byte to write
//   clr_pad_i      : zero the unused lanes of the last word (fill start)
//   raddr_i        : asynchronous read address
//   rdata_o        : word at raddr_i (0 when out of range)
// ----------------------------------------------------------------------------
module weight_loader_pack_ram
  import weight_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [3:0]        wslot_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              clr_pad_i,
  input  logic [3:0]        raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [N_WORD];

  // Byte-lane writes and pad clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < N_WORD; w++) begin
        mem_q[w] <= {WORD_W{1'b0}};
      end
    end else begin
      for (int w = 0; w < N_WORD; w++) begin
        if (we_i && (waddr_i == 4'(w))) begin
          mem_q[w] <= merge_lane(mem_q[w], wslot_i, wdata_i);
        end
      end
      // Pad clear is issued with byte 0, which lands in word 0, so the two
      // writes never touch the same word.
      if (clr_pad_i) begin
        mem_q[N_WORD-1][WORD_W-1:PAD_LO] <= {(WORD_W-PAD_LO){1'b0}};
      end
    end
  end

  // Asynchronous read port with out-of-range guard.
  always_comb begin
    rdata_o = {WORD_W{1'b0}};
    if (raddr_i < 4'(N_WORD)) begin
      rdata_o = mem_q[raddr_i];
    end else begin
      rdata_o = {WORD_W{1'b0}};
    end
  end

endmodule

// File: rtl/weight_loader.sv
// ----------------------------------------------------------------------------
// weight_loader
// Write-side feeder for the layer-1 weight buffer. Packs 77 weight bytes
// (k = 7*row + col) into nine 72-bit words, shifts them into the buffer's
// DFF chain (word 8 first, word 0 last) and issues a one-cycle update strobe
// when the consumer allows a swap.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous reset, active low
//   w_i         : weight byte, natural order k = 0..76
//   w_valid_i   : w_i valid
//   w_ready_o   : byte accepted when w_valid_i & w_ready_o
//   swap_req_i  : level, swap allowed (consumer at pass boundary)
//   weight_o    : packed word to chain input
//   en_DFF_o    : chain shift enable
//   ud_o        : one-cycle update strobe to the current-weight array
//   loaded_o    : chain holds a complete, not-yet-swapped set
// Configuration macro: WEIGHT_PREFETCH_EN -- when defined, the next set fills
// the pack RAM while the chain waits in LOADED; otherwise filling is allowed
// only while the FSM is in FILL.
// ----------------------------------------------------------------------------
module weight_loader
  import weight_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     w_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic              swap_req_i,
  output logic [WORD_W-1:0] weight_o,
  output logic              en_DFF_o,
  output logic              ud_o,
  output logic              loaded_o
);

  state_e            state_q;
  logic              ready_q, ready_d;
  logic              en_q, ud_q, loaded_q;
  logic [WORD_W-1:0] weight_q;
  logic [3:0]        idx_q;        // index of the word currently on weight_o
  logic              full_q, full_d;
  logic [3:0]        slot_q, slot_d;
  logic [3:0]        word_q, word_d;
  logic [6:0]        k_q, k_d;

  logic              xfer_s, last_s, avail_s, shift_done_s;
  logic [3:0]        rd_addr_s;
  logic [WORD_W-1:0] rdata_s, first_word_s;

  weight_loader_pack_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (xfer_s),
    .waddr_i   (word_q),
    .wslot_i   (slot_q),
    .wdata_i   (w_i),
    .clr_pad_i (xfer_s & (k_q == 7'd0)),
    .raddr_i   (rd_addr_s),
    .rdata_o   (rdata_s)
  );

  // Handshake, RAM-full tracking and read-side word selection.
  always_comb begin
    xfer_s       = w_valid_i & ready_q;
    last_s       = xfer_s & (k_q == K_LAST);
    avail_s      = full_q | last_s;
    shift_done_s = (state_q == ST_SHIFT) & (idx_q == 4'd0);
    rd_addr_s    = WORD_LAST;
    if (state_q == ST_SHIFT) begin
      rd_addr_s = idx_q - 4'd1;
    end else begin
      rd_addr_s = WORD_LAST;
    end
    // Byte 76 is still being written when the shift starts; bypass it into
    // word 8 so the first en_DFF_o cycle can follow the last byte directly.
    first_word_s = rdata_s;
    if (last_s) begin
      first_word_s = merge_lane(rdata_s, slot_q, w_i);
    end else begin
      first_word_s = rdata_s;
    end
    // The RAM is busy from the last byte until the chain has read word 0.
    full_d = full_q;
    if (last_s) begin
      full_d = 1'b1;
    end else if (shift_done_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
`ifdef WEIGHT_PREFETCH_EN
    ready_d = ~full_d;
`else
    // In FILL/SWAP a full RAM always means SHIFT next, so !full_d implies
    // the FSM is (or will be) in FILL.
    ready_d = ~full_d & ((state_q == ST_FILL) | (state_q == ST_SWAP));
`endif
  end

  // Fill counters: slot wraps 8->0 and carries into word; all clear on k=76.
  always_comb begin
    slot_d = slot_q;
    word_d = word_q;
    k_d    = k_q;
    if (last_s) begin
      slot_d = 4'd0;
      word_d = 4'd0;
      k_d    = 7'd0;
    end else if (xfer_s) begin
      k_d = k_q + 7'd1;
      if (slot_q == SLOT_LAST) begin
        slot_d = 4'd0;
        word_d = word_q + 4'd1;
      end else begin
        slot_d = slot_q + 4'd1;
        word_d = word_q;
      end
    end else begin
      slot_d = slot_q;
      word_d = word_q;
      k_d    = k_q;
    end
  end

  // Fill-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= 4'd0;
      word_q  <= 4'd0;
      k_q     <= 7'd0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      word_q  <= word_d;
      k_q     <= k_d;
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end

  // Chain FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      en_q     <= 1'b0;
      ud_q     <= 1'b0;
      loaded_q <= 1'b0;
      weight_q <= {WORD_W{1'b0}};
      idx_q    <= 4'd0;
    end else begin
      en_q     <= 1'b0;
      ud_q     <= 1'b0;
      weight_q <= {WORD_W{1'b0}};
      case (state_q)
        ST_FILL: begin
          if (avail_s) begin
            state_q  <= ST_SHIFT;
            en_q     <= 1'b1;
            weight_q <= first_word_s;
            idx_q    <= WORD_LAST;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_SHIFT: begin
          if (idx_q == 4'd0) begin
            state_q  <= ST_LOADED;
            loaded_q <= 1'b1;
          end else begin
            state_q  <= ST_SHIFT;
            en_q     <= 1'b1;
            weight_q <= rdata_s;
            idx_q    <= idx_q - 4'd1;
          end
        end
        ST_LOADED: begin
          if (swap_req_i) begin
            state_q  <= ST_SWAP;
            ud_q     <= 1'b1;
            loaded_q <= 1'b0;
          end else begin
            state_q <= ST_LOADED;
          end
        end
        ST_SWAP: begin
          // A set prefetched during LOADED starts shifting right after ud_o.
          if (avail_s) begin
            state_q  <= ST_SHIFT;
            en_q     <= 1'b1;
            weight_q <= first_word_s;
            idx_q    <= WORD_LAST;
          end else begin
            state_q <= ST_FILL;
          end
        end
        default: begin
          state_q  <= ST_FILL;
          loaded_q <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready_o = ready_q;
  assign weight_o  = weight_q;
  assign en_DFF_o  = en_q;
  assign ud_o      = ud_q;
  assign loaded_o  = loaded_q;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  w_i;
  logic        w_valid_i;
  logic        w_ready_o;
  logic        swap_req_i;
  logic [71:0] weight_o;
  logic        en_DFF_o;
  logic        ud_o;
  logic        loaded_o;

  int checks = 0;
  int errors = 0;

  weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_i        (w_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .swap_req_i (swap_req_i),
    .weight_o   (weight_o),
    .en_DFF_o   (en_DFF_o),
    .ud_o       (ud_o),
    .loaded_o   (loaded_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference packing: word j, lane s holds byte k=9j+s (value base+k), pads 0.
  function automatic logic [71:0] exp_word(input logic [7:0] base, input int j);
    logic [71:0] r;
    r = 72'h0;
    for (int s = 0; s < 9; s++) begin
      if (9 * j + s < 77) r[s*8 +: 8] = base + 8'(9 * j + s);
    end
    return r;
  endfunction

  // Present bytes base+k, k=0..76; returns cycles used and whether all went in.
  task automatic send_set(input logic [7:0] base, input bit gaps,
                          output int cycles, output bit ok);
    int k;
    k = 0;
    cycles = 0;
    while (k < 77 && cycles < 2000) begin
      w_i = base + 8'(k);
      w_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid_i && w_ready_o) k++;
      step();
      cycles++;
    end
    w_valid_i = 1'b0;
    ok = (k == 77);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    w_valid_i = 1'b0;
    w_i = 8'h00;
    swap_req_i = 1'b0;
    repeat (3) step();
    checks++;
    if ({w_ready_o, en_DFF_o, ud_o, loaded_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/en/ud/ld=%b expected 0000", {w_ready_o, en_DFF_o, ud_o, loaded_o});
    end
    checks++;
    if (weight_o !== 72'h0) begin
      errors++;
      $display("FAIL reset_weight: got %h expected 0", weight_o);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (w_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", w_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_DFF_o !== 1'b0 || ud_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got en=%b ud=%b expected 0 0", i, en_DFF_o, ud_o);
      end
      step();
    end
  endtask

  task automatic test_stream_swap();
    int cyc;
    bit ok;
    swap_req_i = 1'b1;
    send_set(8'h01, 1'b0, cyc, ok);
    checks++;
    if (!ok || cyc != 77) begin
      errors++;
      $display("FAIL stream_accept: got ok=%0d cycles=%0d expected 1 77", ok, cyc);
    end
    checks++;
    if (weight_o !== 72'h00000000_4D4C4B4A49) begin
      errors++;
      $display("FAIL first_word: got %h expected 000000004d4c4b4a49", weight_o);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || ud_o !== 1'b0 || loaded_o !== 1'b0 || weight_o !== exp_word(8'h01, 8 - i)) begin
        errors++;
        $display("FAIL stream_shift[%0d]: got en=%b ud=%b ld=%b w=%h expected 1 0 0 %h",
                 i, en_DFF_o, ud_o, loaded_o, weight_o, exp_word(8'h01, 8 - i));
      end
      if (i == 8) begin
        checks++;
        if (weight_o !== 72'h090807060504030201) begin
          errors++;
          $display("FAIL last_word: got %h expected 090807060504030201", weight_o);
        end
      end
      step();
    end
    checks++;
    if ({en_DFF_o, loaded_o, ud_o} !== 3'b010) begin
      errors++;
      $display("FAIL loaded_gap: got en/ld/ud=%b expected 010", {en_DFF_o, loaded_o, ud_o});
    end
    step();
    checks++;
    if ({en_DFF_o, loaded_o, ud_o} !== 3'b001) begin
      errors++;
      $display("FAIL ud_pulse: got en/ld/ud=%b expected 001", {en_DFF_o, loaded_o, ud_o});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ud_o !== 1'b0 || en_DFF_o !== 1'b0 || w_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL after_swap[%0d]: got ud=%b en=%b rdy=%b expected 0 0 1", i, ud_o, en_DFF_o, w_ready_o);
      end
    end
    swap_req_i = 1'b0;
  endtask

  task automatic test_gaps_late_swap();
    int cyc;
    bit ok;
    swap_req_i = 1'b0;
    send_set(8'h01, 1'b1, cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_accept: got ok=%0d cycles=%0d expected 1", ok, cyc);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || weight_o !== exp_word(8'h01, 8 - i)) begin
        errors++;
        $display("FAIL gap_shift[%0d]: got en=%b w=%h expected 1 %h", i, en_DFF_o, weight_o, exp_word(8'h01, 8 - i));
      end
      step();
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
`ifdef WEIGHT_PREFETCH_EN
      if ({loaded_o, ud_o, en_DFF_o, w_ready_o} !== 4'b1001) begin
        errors++;
        $display("FAIL loaded_wait[%0d]: got ld/ud/en/rdy=%b expected 1001", i, {loaded_o, ud_o, en_DFF_o, w_ready_o});
      end
`else
      if ({loaded_o, ud_o, en_DFF_o, w_ready_o} !== 4'b1000) begin
        errors++;
        $display("FAIL loaded_wait[%0d]: got ld/ud/en/rdy=%b expected 1000", i, {loaded_o, ud_o, en_DFF_o, w_ready_o});
      end
`endif
      step();
    end
    swap_req_i = 1'b1;
    step();
    checks++;
    if ({ud_o, loaded_o} !== 2'b10) begin
      errors++;
      $display("FAIL late_ud: got ud/ld=%b expected 10", {ud_o, loaded_o});
    end
    swap_req_i = 1'b0;
    step();
    checks++;
    if ({ud_o, w_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL late_ud_end: got ud/rdy=%b expected 01", {ud_o, w_ready_o});
    end
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    bit ok;
    swap_req_i = 1'b0;
    send_set(8'h20, 1'b0, cyc, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || weight_o !== exp_word(8'h20, 8 - i)) begin
        errors++;
        $display("FAIL pre_reset_shift[%0d]: got en=%b w=%h expected 1 %h", i, en_DFF_o, weight_o, exp_word(8'h20, 8 - i));
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({en_DFF_o, w_ready_o, loaded_o} !== 3'b000 || weight_o !== 72'h0) begin
      errors++;
      $display("FAIL mid_reset: got en/rdy/ld=%b w=%h expected 000 0", {en_DFF_o, w_ready_o, loaded_o}, weight_o);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    swap_req_i = 1'b1;
    send_set(8'h10, 1'b0, cyc, ok);
    checks++;
    if (!ok || cyc != 77) begin
      errors++;
      $display("FAIL fresh_accept: got ok=%0d cycles=%0d expected 1 77", ok, cyc);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || weight_o !== exp_word(8'h10, 8 - i)) begin
        errors++;
        $display("FAIL fresh_shift[%0d]: got en=%b w=%h expected 1 %h", i, en_DFF_o, weight_o, exp_word(8'h10, 8 - i));
      end
      step();
    end
    checks++;
    if ({en_DFF_o, loaded_o, ud_o} !== 3'b010) begin
      errors++;
      $display("FAIL fresh_loaded: got en/ld/ud=%b expected 010", {en_DFF_o, loaded_o, ud_o});
    end
    step();
    checks++;
    if (ud_o !== 1'b1) begin
      errors++;
      $display("FAIL fresh_ud: got %b expected 1", ud_o);
    end
    swap_req_i = 1'b0;
    step();
  endtask

`ifdef WEIGHT_PREFETCH_EN
  task automatic test_prefetch();
    int cyc;
    bit ok;
    swap_req_i = 1'b0;
    send_set(8'h01, 1'b0, cyc, ok);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || weight_o !== exp_word(8'h01, 8 - i)) begin
        errors++;
        $display("FAIL setA_shift[%0d]: got en=%b w=%h expected 1 %h", i, en_DFF_o, weight_o, exp_word(8'h01, 8 - i));
      end
      step();
    end
    send_set(8'h80, 1'b0, cyc, ok);
    checks++;
    if (!ok || cyc != 77) begin
      errors++;
      $display("FAIL setB_nostall: got ok=%0d cycles=%0d expected 1 77", ok, cyc);
    end
    checks++;
    if ({w_ready_o, loaded_o, en_DFF_o, ud_o} !== 4'b0100) begin
      errors++;
      $display("FAIL setB_full: got rdy/ld/en/ud=%b expected 0100", {w_ready_o, loaded_o, en_DFF_o, ud_o});
    end
    swap_req_i = 1'b1;
    step();
    swap_req_i = 1'b0;
    checks++;
    if ({ud_o, en_DFF_o} !== 2'b10) begin
      errors++;
      $display("FAIL setA_ud: got ud/en=%b expected 10", {ud_o, en_DFF_o});
    end
    step();
    checks++;
    if (weight_o !== 72'h00000000_CCCBCAC9C8) begin
      errors++;
      $display("FAIL setB_first: got %h expected 00000000cccbcac9c8", weight_o);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (en_DFF_o !== 1'b1 || ud_o !== 1'b0 || weight_o !== exp_word(8'h80, 8 - i)) begin
        errors++;
        $display("FAIL setB_shift[%0d]: got en=%b ud=%b w=%h expected 1 0 %h", i, en_DFF_o, ud_o, weight_o, exp_word(8'h80, 8 - i));
      end
      step();
    end
    checks++;
    if ({en_DFF_o, loaded_o} !== 2'b01) begin
      errors++;
      $display("FAIL setB_loaded: got en/ld=%b expected 01", {en_DFF_o, loaded_o});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream_swap();
    test_gaps_late_swap();
    test_reset_mid_shift();
`ifdef WEIGHT_PREFETCH_EN
    test_prefetch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
